// File: rtl/frame_burst_sequencer_pkg.sv
// Shared encodings for the frame burst sequencer and the capture FSM it drives.
// Holds the sequencer state type and the capture mode encoding.
package frame_burst_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_END,
        GAP,
        DONE
    } fsb_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

endpackage

// File: rtl/frame_burst_sequencer_if.sv
// Command, capture-FSM and status bundle of the frame burst sequencer.
// The master side issues commands and returns frameEnd; the slave side is the sequencer.
interface frame_burst_sequencer_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [CNT_W-1:0] cmd_count;
    logic [GAP_W-1:0] cfg_gap;
    logic             abort;
    logic             frameStart;
    logic             mode;
    logic             frameEnd;
    logic             burstDone;
    logic             busy;
    logic [CNT_W-1:0] frame_idx;
    logic             timeout_err;

    modport master (
        output cmd_valid, cmd_mode, cmd_count, cfg_gap, abort, frameEnd,
        input  cmd_ready, frameStart, mode, burstDone, busy, frame_idx, timeout_err
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_count, cfg_gap, abort, frameEnd,
        output cmd_ready, frameStart, mode, burstDone, busy, frame_idx, timeout_err
    );
endinterface

// File: rtl/frame_burst_sequencer_watchdog.sv
// Watchdog for the frame-end wait: counts enabled cycles from a clear and flags
// the cycle on which the count reaches TIMEOUT-1.
module fsb_watchdog #(
    parameter int unsigned      TO_W    = 16,
    parameter logic [TO_W-1:0]  TIMEOUT = '1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_ONE;

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + TO_ONE;
        end
    end

    assign expired = enable && (r_cnt == TO_LAST);
endmodule

// File: rtl/frame_burst_sequencer.sv
// Command-driven sequencer: issues frameStart/mode to the capture FSM, counts frameEnd
// pulses and reports burstDone, with inter-frame gap, watchdog and abort.
module frame_burst_sequencer
    import frame_burst_sequencer_pkg::*;
#(
    parameter int unsigned     CNT_W   = 8,
    parameter int unsigned     GAP_W   = 8,
    parameter int unsigned     TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
    input logic                    clk,
    input logic                    reset_n,
    frame_burst_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   IDX_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    fsb_state_t       r_state;
    logic             r_cmd_ready;
    logic             r_frame_start;
    logic             r_mode;
    logic             r_burst_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_frame_idx;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_count;
    logic [GAP_W-1:0] r_gap;

    logic [CNT_W-1:0] w_cmd_cnt;
    logic [CNT_W:0]   w_idx_next;
    logic             w_abort_hit;
    logic             w_wd_clear;
    logic             w_wd_enable;
    logic             w_wd_expired;

    // A single-frame command or a zero count both run exactly one frame.
    assign w_cmd_cnt   = (bus.cmd_mode == MODE_BURST && bus.cmd_count != '0) ? bus.cmd_count : CNT_ONE;
    assign w_idx_next  = {1'b0, r_frame_idx} + IDX_ONE;
    assign w_abort_hit = bus.abort && (r_state != IDLE);
    assign w_wd_enable = (r_state == WAIT_END);
    assign w_wd_clear  = (r_state != WAIT_END);

    fsb_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_frame_start <= 1'b0;
            r_mode        <= MODE_SINGLE;
            r_burst_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_idx   <= '0;
            r_timeout_err <= 1'b0;
            r_count       <= '0;
            r_gap         <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_burst_done  <= 1'b0;
            // Abort outranks every other event once a command is in flight.
            if (w_abort_hit) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_cmd_ready <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.cmd_valid) begin
                            r_mode        <= bus.cmd_mode;
                            r_count       <= w_cmd_cnt;
                            r_frame_idx   <= '0;
                            r_timeout_err <= 1'b0;
                            r_frame_start <= 1'b1;
                            r_cmd_ready   <= 1'b0;
                            r_busy        <= 1'b1;
                            r_state       <= START;
                        end
                    end
                    START: begin
                        r_state <= WAIT_END;
                    end
                    WAIT_END: begin
                        if (bus.frameEnd) begin
                            r_frame_idx <= w_idx_next[CNT_W-1:0];
                            if (w_idx_next == {1'b0, r_count}) begin
                                r_burst_done <= 1'b1;
                                r_state      <= DONE;
                            end else if (bus.cfg_gap == '0) begin
                                r_frame_start <= 1'b1;
                                r_state       <= START;
                            end else begin
                                r_gap   <= bus.cfg_gap;
                                r_state <= GAP;
                            end
                        end else if (w_wd_expired) begin
                            r_timeout_err <= 1'b1;
                            r_busy        <= 1'b0;
                            r_cmd_ready   <= 1'b1;
                            r_state       <= IDLE;
                        end
                    end
                    GAP: begin
                        if (r_gap == GAP_ONE) begin
                            r_frame_start <= 1'b1;
                            r_state       <= START;
                        end else begin
                            r_gap <= r_gap - GAP_ONE;
                        end
                    end
                    DONE: begin
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: begin
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.frameStart  = r_frame_start;
    assign bus.mode        = r_mode;
    assign bus.burstDone   = r_burst_done;
    assign bus.busy        = r_busy;
    assign bus.frame_idx   = r_frame_idx;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_frame_burst_sequencer.sv
// Directed bench for frame_burst_sequencer with a 16-cycle watchdog.
// Status vectors are ordered {cmd_ready, busy, frameStart, mode, burstDone, timeout_err}.
module tb_frame_burst_sequencer;
    import frame_burst_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    frame_burst_sequencer_if #(.CNT_W(8), .GAP_W(8)) bus ();

    frame_burst_sequencer #(
        .CNT_W   (8),
        .GAP_W   (8),
        .TO_W    (16),
        .TIMEOUT (16'd16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] stat();
        return {bus.cmd_ready, bus.busy, bus.frameStart, bus.mode, bus.burstDone, bus.timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic [7:0] cnt, input logic [7:0] gap);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_count = cnt;
        bus.cfg_gap   = gap;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_mode = MODE_SINGLE; bus.cmd_count = '0;
        bus.cfg_gap = '0; bus.abort = 1'b0; bus.frameEnd = 1'b0;
        reset_n = 1'b0;
        tick();
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL reset_held status: got %b want 100000", stat()); end
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL reset_release status: got %b want 100000", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd0) begin n_errors++; $display("FAIL reset frame_idx: got %0d want 0", bus.frame_idx); end
    endtask

    task automatic test_single();
        int unsigned fs_cnt = 0;
        issue(MODE_SINGLE, 8'd5, 8'd4);
        n_checks++; if (stat() !== 6'b011000) begin n_errors++; $display("FAIL single_accept status: got %b want 011000", stat()); end
        repeat (10) begin
            tick();
            if (bus.frameStart) fs_cnt++;
        end
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b010010) begin n_errors++; $display("FAIL single_done status: got %b want 010010", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd1) begin n_errors++; $display("FAIL single frame_idx: got %0d want 1", bus.frame_idx); end
        n_checks++; if (fs_cnt != 0) begin n_errors++; $display("FAIL single extra_frameStart: got %0d want 0", fs_cnt); end
        tick();
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL single_idle status: got %b want 100000", stat()); end
    endtask

    task automatic test_burst();
        issue(MODE_BURST, 8'd3, 8'd4);
        n_checks++; if (stat() !== 6'b011100) begin n_errors++; $display("FAIL burst_accept status: got %b want 011100", stat()); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            n_checks++; if (stat() !== 6'b010100) begin n_errors++; $display("FAIL burst_wait%0d status: got %b want 010100", k, stat()); end
            bus.frameEnd = 1'b1;
            tick();
            bus.frameEnd = 1'b0;
            n_checks++; if (bus.frame_idx !== 8'(k + 1)) begin n_errors++; $display("FAIL burst_idx%0d: got %0d want %0d", k, bus.frame_idx, k + 1); end
            if (k < 2) begin
                n_checks++; if (stat() !== 6'b010100) begin n_errors++; $display("FAIL burst_gap%0d status: got %b want 010100", k, stat()); end
                for (int j = 0; j < 3; j++) begin
                    tick();
                    n_checks++; if (bus.frameStart !== 1'b0) begin n_errors++; $display("FAIL burst_gap%0d_idle%0d frameStart: got %b want 0", k, j, bus.frameStart); end
                end
                tick();
                n_checks++; if (stat() !== 6'b011100) begin n_errors++; $display("FAIL burst_restart%0d status: got %b want 011100", k, stat()); end
            end else begin
                n_checks++; if (stat() !== 6'b010110) begin n_errors++; $display("FAIL burst_done status: got %b want 010110", stat()); end
            end
        end
        tick();
        n_checks++; if (stat() !== 6'b100100) begin n_errors++; $display("FAIL burst_idle status: got %b want 100100", stat()); end
    endtask

    task automatic test_zero_values();
        issue(MODE_BURST, 8'd0, 8'd0);
        tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b010110) begin n_errors++; $display("FAIL zero_count status: got %b want 010110", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd1) begin n_errors++; $display("FAIL zero_count frame_idx: got %0d want 1", bus.frame_idx); end
        tick();
        issue(MODE_BURST, 8'd2, 8'd0);
        tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b011100) begin n_errors++; $display("FAIL zero_gap restart status: got %b want 011100", stat()); end
        tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b010110) begin n_errors++; $display("FAIL zero_gap done status: got %b want 010110", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd2) begin n_errors++; $display("FAIL zero_gap frame_idx: got %0d want 2", bus.frame_idx); end
        tick();
    endtask

    task automatic test_abort();
        int unsigned seen = 0;
        issue(MODE_BURST, 8'd4, 8'd4);
        for (int k = 0; k < 2; k++) begin
            tick();
            bus.frameEnd = 1'b1;
            tick();
            bus.frameEnd = 1'b0;
            if (k == 0) repeat (4) tick();
        end
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++; if (stat() !== 6'b100100) begin n_errors++; $display("FAIL abort_gap status: got %b want 100100", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd2) begin n_errors++; $display("FAIL abort_gap frame_idx: got %0d want 2", bus.frame_idx); end
        repeat (6) begin
            tick();
            if (bus.frameStart || bus.burstDone || bus.busy) seen++;
        end
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL abort_quiet activity: got %0d want 0", seen); end
        issue(MODE_BURST, 8'd3, 8'd0);
        tick();
        bus.frameEnd = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        bus.abort    = 1'b0;
        n_checks++; if (stat() !== 6'b100100) begin n_errors++; $display("FAIL abort_vs_end status: got %b want 100100", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd0) begin n_errors++; $display("FAIL abort_vs_end frame_idx: got %0d want 0", bus.frame_idx); end
        bus.abort = 1'b1;
        issue(MODE_SINGLE, 8'd1, 8'd0);
        n_checks++; if (stat() !== 6'b011000) begin n_errors++; $display("FAIL abort_idle accept status: got %b want 011000", stat()); end
        tick();
        bus.abort = 1'b0;
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL abort_start status: got %b want 100000", stat()); end
    endtask

    task automatic test_timeout();
        issue(MODE_SINGLE, 8'd1, 8'd0);
        repeat (16) tick();
        n_checks++; if (stat() !== 6'b010000) begin n_errors++; $display("FAIL timeout_pre status: got %b want 010000", stat()); end
        tick();
        n_checks++; if (stat() !== 6'b100001) begin n_errors++; $display("FAIL timeout_hit status: got %b want 100001", stat()); end
        repeat (3) tick();
        n_checks++; if (stat() !== 6'b100001) begin n_errors++; $display("FAIL timeout_sticky status: got %b want 100001", stat()); end
        issue(MODE_SINGLE, 8'd1, 8'd0);
        n_checks++; if (stat() !== 6'b011000) begin n_errors++; $display("FAIL timeout_clear status: got %b want 011000", stat()); end
        repeat (16) tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b010010) begin n_errors++; $display("FAIL timeout_race status: got %b want 010010", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd1) begin n_errors++; $display("FAIL timeout_race frame_idx: got %0d want 1", bus.frame_idx); end
        tick();
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL timeout_race idle status: got %b want 100000", stat()); end
    endtask

    task automatic test_reset_mid_burst();
        issue(MODE_BURST, 8'd3, 8'd2);
        tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        tick();
        tick();
        n_checks++; if (stat() !== 6'b011100) begin n_errors++; $display("FAIL midrst_restart status: got %b want 011100", stat()); end
        tick();
        tick();
        reset_n = 1'b0;
        #2;
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL midrst_async status: got %b want 100000", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd0) begin n_errors++; $display("FAIL midrst_async frame_idx: got %0d want 0", bus.frame_idx); end
        bus.frameEnd = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        tick();
        n_checks++; if (stat() !== 6'b100000) begin n_errors++; $display("FAIL midrst_after status: got %b want 100000", stat()); end
        n_checks++; if (bus.frame_idx !== 8'd0) begin n_errors++; $display("FAIL midrst_after frame_idx: got %0d want 0", bus.frame_idx); end
        issue(MODE_SINGLE, 8'd7, 8'd0);
        n_checks++; if (stat() !== 6'b011000) begin n_errors++; $display("FAIL midrst_recover status: got %b want 011000", stat()); end
        tick();
        bus.frameEnd = 1'b1;
        tick();
        bus.frameEnd = 1'b0;
        n_checks++; if (stat() !== 6'b010010) begin n_errors++; $display("FAIL midrst_recover done status: got %b want 010010", stat()); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_zero_values();
        test_abort();
        test_timeout();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
